// File: rtl/dm_dmi_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_dmi_arb_pkg -- shared definitions for the DMI arbiter slice
//
// Holds the arbiter state encoding and a width helper used by both the
// arbiter top and its ID FIFO.
// ---------------------------------------------------------------------------
package dm_dmi_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for n items, never narrower than one bit so that a
    // single-entry structure still has a legal vector.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg -- debug-module DMI transport types
//
// Defines the request and response payloads carried on the DMI link between
// the debug transports (JTAG DTM and friends) and the debug module.
//   dmi_req_t  : 41 bits = addr[6:0] + op[1:0] + data[31:0]
//   dmi_resp_t : 34 bits = data[31:0] + resp[1:0]
// ---------------------------------------------------------------------------
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_id_fifo.sv
// ---------------------------------------------------------------------------
// dm_dmi_id_fifo -- in-order FIFO of requester indices
//
// Remembers which transport issued each outstanding DMI request so that
// responses, which the DM returns strictly in order, can be steered back.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write data_i (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   data_i         requester index to store
//   data_o         requester index at the head
//   full_o         Depth entries held
//   empty_o        no entries held
//   usage_o        number of entries held
// ---------------------------------------------------------------------------
module dm_dmi_id_fifo
    import dm_dmi_arb_pkg::*;
#(
    parameter int  Depth = 2,
    parameter int  Width = 1,
    localparam int PtrW  = idxWidth(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW:0]    usage_o
);

    localparam int Slots = 2 ** PtrW;

    logic [PtrW:0]    r_wrPtr;
    logic [PtrW:0]    r_rdPtr;
    logic [Width-1:0] r_mem [Slots];
    logic [PtrW:0]    w_usage;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit, so their difference is the fill
    // level directly; equal pointers mean empty, a difference of Depth means
    // full. Comparing the fill level also covers Depth = 1.
    assign w_usage = r_wrPtr - r_rdPtr;
    assign usage_o = w_usage;
    assign empty_o = (w_usage == '0);
    assign full_o  = (w_usage == (PtrW + 1)'(Depth));
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rdPtr[PtrW-1:0]];

    // Pointer registers: each advances by one on its own handshake; an
    // asynchronous reset empties the FIFO without touching the storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dm_dmi_arb.sv
// ---------------------------------------------------------------------------
// dm_dmi_arb -- round-robin arbiter sharing one DMI target among transports
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready  per-requester request handshake (ready is zero-latency)
//   req_i              per-requester request payload
//   resp_valid_o/ready per-requester response handshake
//   resp_o             DM response, broadcast; qualified by resp_valid_o
//   dmi_req_*          request channel towards the DM
//   dmi_resp_*         response channel from the DM
//   unexp_resp_o       sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module dm_dmi_arb
    import dm_dmi_arb_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int MaxOutstanding = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic          [NumReq-1:0] req_valid_i,
    output logic          [NumReq-1:0] req_ready_o,
    input  dm::dmi_req_t  [NumReq-1:0] req_i,
    output logic          [NumReq-1:0] resp_valid_o,
    input  logic          [NumReq-1:0] resp_ready_i,
    output dm::dmi_resp_t              resp_o,
    output logic                       dmi_req_valid_o,
    input  logic                       dmi_req_ready_i,
    output dm::dmi_req_t               dmi_req_o,
    input  logic                       dmi_resp_valid_i,
    output logic                       dmi_resp_ready_o,
    input  dm::dmi_resp_t              dmi_resp_i,
    output logic                       unexp_resp_o
);

    localparam int IdxW   = idxWidth(NumReq);
    localparam int UsageW = idxWidth(MaxOutstanding) + 1;

    arb_state_e        r_state;
    arb_state_e        w_stateNext;
    logic [IdxW-1:0]   r_rrPtr;
    logic [IdxW-1:0]   r_lockIdx;
    logic              r_unexp;
    logic [IdxW-1:0]   w_grantIdx;
    logic [IdxW-1:0]   w_cand;
    logic              w_grantValid;
    logic              w_issue;
    logic              w_accept;
    logic [IdxW-1:0]   w_headIdx;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic              w_pop;
    logic              w_unexpSet;
    logic [UsageW-1:0] w_usage;
    logic              w_unusedUsage;

    // Grant selection. While locked the grant is pinned to the requester
    // whose offer the DM has not yet taken, so the DM never sees the
    // request change under it. Otherwise scan from the round-robin pointer
    // upward, wrapping, and take the first requester with valid set.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        if (r_state == ARB_LOCKED) begin
            w_grantIdx   = r_lockIdx;
            w_grantValid = req_valid_i[r_lockIdx];
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                w_cand = IdxW'((int'(r_rrPtr) + k) % NumReq);
                if (!w_grantValid && req_valid_i[w_cand]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_cand;
                end
            end
        end
    end

    // A request may only be offered when the ID FIFO has room for its tag;
    // a pop in the same cycle does not free that room early.
    assign w_issue  = w_grantValid & ~w_fifoFull;
    assign w_accept = w_issue & dmi_req_ready_i;

    // Arbiter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: lock as soon as an offer is left hanging, release
    // on the accept that finally consumes it.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_issue && !w_accept) begin
                    w_stateNext = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (w_accept) begin
                    w_stateNext = ARB_IDLE;
                end
            end
            default: w_stateNext = ARB_IDLE;
        endcase
    end

    // Round-robin pointer moves past whoever just won, and the lock index
    // is captured on the same edge that enters the locked state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rrPtr   <= '0;
            r_lockIdx <= '0;
        end else begin
            if (w_accept) begin
                if (w_grantIdx == IdxW'(NumReq - 1)) begin
                    r_rrPtr <= '0;
                end else begin
                    r_rrPtr <= w_grantIdx + 1'b1;
                end
            end
            if (r_state == ARB_IDLE && w_stateNext == ARB_LOCKED) begin
                r_lockIdx <= w_grantIdx;
            end
        end
    end

    // Request-side outputs. All handshakes are held quiet while reset is
    // asserted so neither side can complete a transfer during reset.
    always_comb begin
        req_ready_o     = '0;
        dmi_req_valid_o = 1'b0;
        dmi_req_o       = '0;
        if (rst_ni) begin
            dmi_req_valid_o = w_issue;
            if (w_grantValid) begin
                dmi_req_o = req_i[w_grantIdx];
            end
            if (w_accept) begin
                req_ready_o[w_grantIdx] = 1'b1;
            end
        end
    end

    // Response routing. With a tag outstanding, the head of the FIFO names
    // the only requester that may see this response and supplies its ready.
    // With nothing outstanding the response is swallowed and flagged.
    always_comb begin
        resp_valid_o     = '0;
        dmi_resp_ready_o = 1'b0;
        w_pop            = 1'b0;
        w_unexpSet       = 1'b0;
        if (rst_ni) begin
            if (!w_fifoEmpty) begin
                resp_valid_o[w_headIdx] = dmi_resp_valid_i;
                dmi_resp_ready_o        = resp_ready_i[w_headIdx];
                w_pop                   = dmi_resp_valid_i & resp_ready_i[w_headIdx];
            end else begin
                dmi_resp_ready_o = 1'b1;
                w_unexpSet       = dmi_resp_valid_i;
            end
        end
    end

    assign resp_o = rst_ni ? dmi_resp_i : '0;

    // Sticky unexpected-response flag; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_unexp <= 1'b0;
        end else if (w_unexpSet) begin
            r_unexp <= 1'b1;
        end
    end

    assign unexp_resp_o = r_unexp;

    dm_dmi_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_idFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_accept),
        .pop_i   (w_pop),
        .data_i  (w_grantIdx),
        .data_o  (w_headIdx),
        .full_o  (w_fifoFull),
        .empty_o (w_fifoEmpty),
        .usage_o (w_usage)
    );

    // The fill level is exported by the FIFO for observability only.
    assign w_unusedUsage = ^w_usage;

endmodule
